// File: rtl/gate_unit_pipe.sv
// Purpose  : pipelined bitwise logic unit (AND/NAND/OR/NOR/XOR/XNOR/NOT a) with reduction flags,
//            a reserved-opcode error flag and an accepted-transaction counter.
// Latency  : STAGES cycles from the input handshake to out_valid, one transaction per cycle sustained.
// Backpres.: full valid/ready; bubbles collapse, in_ready falls only once every stage holds data.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake carrying a, b, op
//   a, b [WIDTH]          operands (b unused by NOT a)
//   op [3]                000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 reserved
//   out_valid/out_ready   output handshake carrying y, y_all, y_any, err
//   y [WIDTH]             bitwise result; y_all / y_any are its AND / OR reductions
//   err                   transaction carried the reserved opcode (its y is 0)
//   txn_count [CNT_W]     accepted input transactions, wraps silently
module gate_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic             err,
    output logic [CNT_W-1:0] txn_count
);

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] y;
    } stage_t;

    stage_t             res_d;
    stage_t             st_q [STAGES];
    logic [STAGES-1:0]  v_q;
    logic [STAGES-1:0]  ld;
    logic               acc;
    logic [CNT_W-1:0]   cnt_q;

    // Combinational result, captured into stage 0 on the input handshake.
    always_comb begin
        res_d = '0;
        unique case (op)
            3'b000: res_d.y = a & b;
            3'b001: res_d.y = ~(a & b);
            3'b010: res_d.y = a | b;
            3'b011: res_d.y = ~(a | b);
            3'b100: res_d.y = a ^ b;
            3'b101: res_d.y = ~(a ^ b);
            3'b110: res_d.y = ~a;
            3'b111: res_d.err = 1'b1;
        endcase
    end

    // Stage i may load unless it and every stage after it are full while the
    // consumer stalls. Written as a direct scan rather than a ripple chain so
    // no vector bit depends on another bit of the same vector.
    always_comb begin
        ld = '0;
        for (int i = 0; i < STAGES; i++) begin
            ld[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!v_q[j]) begin
                    ld[i] = 1'b1;
                end
            end
        end
    end

    // Held low while reset is asserted so nothing is accepted into a pipe
    // that is being cleared.
    assign in_ready = ld[0] & rst_n;
    assign acc      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_q[i] <= '0;
            end
        end else begin
            if (ld[0]) begin
                v_q[0] <= in_valid;
            end
            if (acc) begin
                st_q[0] <= res_d;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            // Whenever stage i loads, stage i-1 is vacating too, so the
            // valid bit simply moves forward; data follows only real entries.
            for (int i = 1; i < STAGES; i++) begin
                if (ld[i]) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        st_q[i] <= st_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign y         = st_q[STAGES-1].y;
    assign err       = st_q[STAGES-1].err;
    assign y_all     = &st_q[STAGES-1].y;
    assign y_any     = |st_q[STAGES-1].y;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Purpose  : bench for gate_unit_pipe; three instances (8b/2 stages/4b counter, 1b/1 stage, 32b/4 stages).
// Latency  : expected results queued at each input handshake, compared when the output handshakes.
// Backpres.: out_ready driven directly, held low for stall checks or randomized per cycle.
module tb_gate_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_n_s     [3];
    logic        in_valid_s  [3];
    logic        in_ready_s  [3];
    logic        out_valid_s [3];
    logic        out_ready_s [3];
    logic        y_all_s     [3];
    logic        y_any_s     [3];
    logic        err_s       [3];
    logic [31:0] a_s         [3];
    logic [31:0] b_s         [3];
    logic [2:0]  op_s        [3];

    logic [7:0]  y0;
    logic [0:0]  y1;
    logic [31:0] y2;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;
    logic [15:0] cnt2;

    bit          rnd_rdy [3];
    bit          done    [3];
    int          n_acc   [3];
    int          n_out   [3];

    logic [32:0] sb0 [$];
    logic [32:0] sb1 [$];
    logic [32:0] sb2 [$];

    logic [31:0] ba [6];
    logic [31:0] bb [6];
    logic [2:0]  bo [6];

    gate_unit_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .op(op_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]), .y(y0), .y_all(y_all_s[0]), .y_any(y_any_s[0]),
        .err(err_s[0]), .txn_count(cnt0)
    );

    gate_unit_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1][0:0]), .b(b_s[1][0:0]), .op(op_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]), .y(y1), .y_all(y_all_s[1]), .y_any(y_any_s[1]),
        .err(err_s[1]), .txn_count(cnt1)
    );

    gate_unit_pipe #(.WIDTH(32), .STAGES(4), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n_s[2]), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2]), .b(b_s[2]), .op(op_s[2]), .out_valid(out_valid_s[2]),
        .out_ready(out_ready_s[2]), .y(y2), .y_all(y_all_s[2]), .y_any(y_any_s[2]),
        .err(err_s[2]), .txn_count(cnt2)
    );

    // ---------------- configuration / accessors ----------------
    function automatic int wid(int k);
        return (k == 0) ? 8 : (k == 1) ? 1 : 32;
    endfunction

    function automatic int stg(int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] get_y(int k);
        return (k == 0) ? {24'b0, y0} : (k == 1) ? {31'b0, y1} : y2;
    endfunction

    function automatic logic [15:0] get_cnt(int k);
        return (k == 0) ? {12'b0, cnt0} : (k == 1) ? cnt1 : cnt2;
    endfunction

    function automatic logic [15:0] cnt_mask(int k);
        return (k == 0) ? 16'h000F : 16'hFFFF;
    endfunction

    // ---------------- reference model ----------------
    // Each opcode is a two-input truth table indexed by {a_bit, b_bit};
    // the result is that table applied to every bit position.
    function automatic logic [32:0] model(int w, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        logic [3:0]  tt;
        logic [31:0] r;
        r = '0;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b0111;
            3'd2:    tt = 4'b1110;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b0000;
        endcase
        for (int i = 0; i < w; i++) begin
            r[i] = tt[{a[i], b[i]}];
        end
        return {op == 3'b111, r};
    endfunction

    // Published results for a=F0, b=CC.
    function automatic logic [7:0] sweep_y(int op);
        case (op)
            0:       return 8'hC0;
            1:       return 8'h3F;
            2:       return 8'hFC;
            3:       return 8'h03;
            4:       return 8'h3C;
            5:       return 8'hC3;
            default: return 8'h0F;
        endcase
    endfunction

    // ---------------- scoreboard queues ----------------
    function automatic int qsize(int k);
        return (k == 0) ? sb0.size() : (k == 1) ? sb1.size() : sb2.size();
    endfunction

    task automatic qpush(int k, logic [32:0] e);
        case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic qpop(int k, output logic [32:0] e);
        case (k)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
    endtask

    task automatic qclear(int k);
        case (k)
            0:       sb0.delete();
            1:       sb1.delete();
            default: sb2.delete();
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(int k);
        logic [32:0] e;
        logic [31:0] m;
        m = (wid(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(k)) - 32'd1);
        n_out[k]++;
        if (qsize(k) == 0) begin
            chk($sformatf("u%0d_unexpected_output", k), 64'(get_y(k)), 64'hDEAD);
        end else begin
            qpop(k, e);
            chk($sformatf("u%0d_y", k), 64'(get_y(k)), 64'(e[31:0]));
            chk($sformatf("u%0d_err", k), 64'(err_s[k]), 64'(e[32]));
            chk($sformatf("u%0d_y_all", k), 64'(y_all_s[k]), 64'(e[31:0] == m));
            chk($sformatf("u%0d_y_any", k), 64'(y_any_s[k]), 64'(e[31:0] != 32'd0));
        end
    endtask

    // Monitor: compares whenever an output handshake is about to happen.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n_s[k] === 1'b1 && out_valid_s[k] === 1'b1 && out_ready_s[k] === 1'b1) begin
                check_out(k);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int k);
        @(posedge clk);
        #1;
        if (rnd_rdy[k]) begin
            out_ready_s[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [32:0] e);
        bit acc;
        acc = 1'b0;
        in_valid_s[k] = 1'b1;
        a_s[k]  = a;
        b_s[k]  = b;
        op_s[k] = op;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (in_ready_s[k]) begin
                qpush(k, e);
                n_acc[k]++;
                acc = 1'b1;
            end
            tick(k);
        end
        in_valid_s[k] = 1'b0;
        chk($sformatf("u%0d_accepted", k), 64'(acc), 64'd1);
    endtask

    task automatic rissue(int k);
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(0, 7));
        issue(k, a, b, op, model(wid(k), a, b, op));
    endtask

    task automatic drain(int k);
        rnd_rdy[k]     = 1'b0;
        out_ready_s[k] = 1'b1;
        for (int t = 0; t < 200 && (qsize(k) != 0 || out_valid_s[k]); t++) begin
            tick(k);
        end
        chk($sformatf("u%0d_drain_left", k), 64'(qsize(k)), 64'd0);
        chk($sformatf("u%0d_idle_valid", k), 64'(out_valid_s[k]), 64'd0);
    endtask

    // Pipe must be empty on entry; measures negedges from acceptance to out_valid.
    task automatic latency(int k);
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        lat = 0;
        a   = $urandom;
        b   = $urandom;
        op  = 3'($urandom_range(0, 6));
        out_ready_s[k] = 1'b1;
        issue(k, a, b, op, model(wid(k), a, b, op));
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (out_valid_s[k] && lat == 0) begin
                lat = t;
            end
        end
        tick(k);
        chk($sformatf("u%0d_latency", k), 64'(lat), 64'(stg(k)));
    endtask

    task automatic rst_chk(int k, string tag);
        chk($sformatf("u%0d_%s_out_valid", k, tag), 64'(out_valid_s[k]), 64'd0);
        chk($sformatf("u%0d_%s_y", k, tag), 64'(get_y(k)), 64'd0);
        chk($sformatf("u%0d_%s_err", k, tag), 64'(err_s[k]), 64'd0);
        chk($sformatf("u%0d_%s_y_all", k, tag), 64'(y_all_s[k]), 64'd0);
        chk($sformatf("u%0d_%s_y_any", k, tag), 64'(y_any_s[k]), 64'd0);
        chk($sformatf("u%0d_%s_in_ready", k, tag), 64'(in_ready_s[k]), 64'd0);
        chk($sformatf("u%0d_%s_txn_count", k, tag), 64'(get_cnt(k)), 64'd0);
    endtask

    task automatic run_sweep(int k);
        rst_n_s[k]     = 1'b0;
        in_valid_s[k]  = 1'b0;
        out_ready_s[k] = 1'b1;
        a_s[k]         = '0;
        b_s[k]         = '0;
        op_s[k]        = '0;
        #13;
        rst_chk(k, "reset");
        @(negedge clk);
        rst_n_s[k] = 1'b1;
        tick(k);
        chk($sformatf("u%0d_ready_after_reset", k), 64'(in_ready_s[k]), 64'd1);
        latency(k);
        rnd_rdy[k] = 1'b1;
        repeat (200) rissue(k);
        drain(k);
        chk($sformatf("u%0d_txn_count", k), 64'(get_cnt(k)), 64'(n_acc[k] & cnt_mask(k)));
        done[k] = 1'b1;
    endtask

    initial run_sweep(1);
    initial run_sweep(2);

    // ---------------- directed + random sequence on the 8-bit instance ----------------
    initial begin
        int          cnt_before;
        int          out_before;
        logic [31:0] hold_y;

        rst_n_s[0]     = 1'b0;
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        a_s[0]         = '0;
        b_s[0]         = '0;
        op_s[0]        = '0;
        #12;
        rst_chk(0, "reset");
        @(negedge clk);
        rst_n_s[0] = 1'b1;
        tick(0);
        chk("u0_ready_after_reset", 64'(in_ready_s[0]), 64'd1);

        // Truth sweep, back-to-back.
        for (int o = 0; o < 7; o++) begin
            issue(0, 32'hF0, 32'hCC, 3'(o), {1'b0, 24'b0, sweep_y(o)});
        end
        drain(0);
        chk("u0_txn_count_sweep", 64'(cnt0), 64'd7);

        // Reserved opcode and full-ones reductions.
        issue(0, 32'hFF, 32'hFF, 3'b111, {1'b1, 32'h0});
        issue(0, 32'hFF, 32'hFF, 3'b000, {1'b0, 32'hFF});
        drain(0);
        latency(0);

        // Backpressure: two accepts fill the pipe, the third is refused.
        for (int i = 0; i < 6; i++) begin
            ba[i] = $urandom;
            bb[i] = $urandom;
            bo[i] = 3'($urandom_range(0, 7));
        end
        cnt_before = n_acc[0];
        out_before = n_out[0];
        out_ready_s[0] = 1'b0;
        issue(0, ba[0], bb[0], bo[0], model(8, ba[0], bb[0], bo[0]));
        issue(0, ba[1], bb[1], bo[1], model(8, ba[1], bb[1], bo[1]));
        hold_y = model(8, ba[0], bb[0], bo[0]);
        in_valid_s[0] = 1'b1;
        a_s[0]  = ba[2];
        b_s[0]  = bb[2];
        op_s[0] = bo[2];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("u0_stall_in_ready", 64'(in_ready_s[0]), 64'd0);
            chk("u0_stall_out_valid", 64'(out_valid_s[0]), 64'd1);
            chk("u0_stall_y", 64'(get_y(0)), 64'(hold_y[7:0]));
            chk("u0_stall_txn_count", 64'(cnt0), 64'((cnt_before + 2) & 15));
            tick(0);
        end
        out_ready_s[0] = 1'b1;
        for (int i = 2; i < 6; i++) begin
            issue(0, ba[i], bb[i], bo[i], model(8, ba[i], bb[i], bo[i]));
        end
        drain(0);
        chk("u0_stall_out_count", 64'(n_out[0] - out_before), 64'd6);

        // Asynchronous reset between edges with both stages full.
        out_ready_s[0] = 1'b0;
        rissue(0);
        rissue(0);
        @(negedge clk);
        #2;
        rst_n_s[0] = 1'b0;
        #1;
        rst_chk(0, "midreset");
        qclear(0);
        n_acc[0] = 0;
        @(negedge clk);
        rst_n_s[0] = 1'b1;
        tick(0);
        chk("u0_ready_after_midreset", 64'(in_ready_s[0]), 64'd1);
        latency(0);

        // 17 accepts since reset on a 4-bit counter.
        repeat (16) rissue(0);
        drain(0);
        chk("u0_txn_count_wrap", 64'(cnt0), 64'd1);

        // Random traffic with random consumer stalls.
        rnd_rdy[0] = 1'b1;
        repeat (150) rissue(0);
        drain(0);
        chk("u0_txn_count_final", 64'(cnt0), 64'(n_acc[0] & 15));

        for (int t = 0; t < 5000 && !(done[1] && done[2]); t++) begin
            @(posedge clk);
        end
        chk("sweeps_done", 64'(done[1] && done[2]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
